// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: frames become visible downstream only once complete.
// Optional macro AXIS_PKT_FIFO_BAD_DROP_EN adds s_axis_tuser to discard frames flagged bad on tlast.
module axis_pkt_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int DROP_CNT_W = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
  input  logic                  s_axis_tuser,
`endif
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_W:0]       pkt_count,
  output logic [ADDR_W:0]       fill_level,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_t;

  function automatic logic [DROP_CNT_W-1:0] f_sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [DATA_W:0]       r_mem [DEPTH];
  wr_state_t             r_wr_state;
  logic [ADDR_W:0]       r_wr_cur;
  logic [ADDR_W:0]       r_wr_commit;
  logic [ADDR_W:0]       r_wr_commit_d;
  logic [ADDR_W:0]       r_rd_ptr;
  logic [ADDR_W:0]       r_pkt_count;
  logic [DROP_CNT_W-1:0] r_drop_count;
  logic [DATA_W-1:0]     r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;

  logic                  w_bad;
  logic [ADDR_W:0]       w_rd_base;
  logic                  w_full;
  logic                  w_reject;
  logic                  w_mem_we;
  logic                  w_commit;
  logic                  w_m_hs;
  logic                  w_rd_last;
  logic                  w_rd_avail;
  logic                  w_load;

`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
  assign w_bad = s_axis_tuser;
`else
  assign w_bad = 1'b0;
`endif

  // The beat parked in the output register still occupies its slot until handed off.
  assign w_rd_base  = r_rd_ptr - {{ADDR_W{1'b0}}, r_m_tvalid};
  assign w_full     = ((r_wr_cur - w_rd_base) == DEPTH_P);
  assign w_reject   = w_full || (s_axis_tlast && w_bad);
  assign w_mem_we   = s_axis_tvalid && (r_wr_state == ST_ACCEPT) && !w_reject;
  assign w_commit   = w_mem_we && s_axis_tlast;
  assign w_m_hs     = r_m_tvalid && m_axis_tready;
  assign w_rd_last  = w_m_hs && r_m_tlast;
  // Delayed commit pointer gives the read side one cycle of memory-read slack.
  assign w_rd_avail = (r_rd_ptr != r_wr_commit_d) && (r_pkt_count != '0);
  assign w_load     = (!r_m_tvalid || m_axis_tready) && w_rd_avail;

  assign s_axis_tready = ~areset;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign pkt_count     = r_pkt_count;
  assign fill_level    = r_wr_commit - w_rd_base;
  assign drop_count    = r_drop_count;

  // Beat storage, tlast kept alongside the data.
  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      r_mem[r_wr_cur[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Write-side FSM: accept or drop frames, commit on tlast, count drops.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_state    <= ST_ACCEPT;
      r_wr_cur      <= '0;
      r_wr_commit   <= '0;
      r_wr_commit_d <= '0;
      r_drop_count  <= '0;
    end else begin
      r_wr_commit_d <= r_wr_commit;
      if (s_axis_tvalid) begin
        case (r_wr_state)
          ST_ACCEPT: begin
            if (w_reject) begin
              r_wr_cur <= r_wr_commit;
              if (s_axis_tlast) begin
                r_drop_count <= f_sat_inc(r_drop_count);
              end else begin
                r_wr_state <= ST_DROP;
              end
            end else begin
              r_wr_cur <= r_wr_cur + PTR_ONE;
              if (s_axis_tlast) begin
                r_wr_commit <= r_wr_cur + PTR_ONE;
              end
            end
          end
          ST_DROP: begin
            if (s_axis_tlast) begin
              r_drop_count <= f_sat_inc(r_drop_count);
              r_wr_state   <= ST_ACCEPT;
            end
          end
          default: begin
            r_wr_state <= ST_ACCEPT;
            r_wr_cur   <= r_wr_commit;
          end
        endcase
      end
    end
  end

  // Complete-frame counter; simultaneous commit and read-out cancel.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_commit, w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + PTR_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - PTR_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // One-entry output register, prefetched from committed data.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_ptr   <= '0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_load) begin
      r_m_tdata  <= r_mem[r_rd_ptr[ADDR_W-1:0]][DATA_W-1:0];
      r_m_tlast  <= r_mem[r_rd_ptr[ADDR_W-1:0]][DATA_W];
      r_m_tvalid <= 1'b1;
      r_rd_ptr   <= r_rd_ptr + PTR_ONE;
    end else if (w_m_hs) begin
      r_m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo (DEPTH=16) against a frame-level queue model.
// Covers AXIS_PKT_FIFO_BAD_DROP_EN when that macro is defined.
module tb_axis_pkt_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int DCW   = 16;
  localparam int AW    = 4;
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif

  logic           aclk = 1'b0;
  logic           areset;
  logic [DW-1:0]  s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tlast;
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
  logic           s_axis_tuser;
`endif
  logic           s_axis_tready;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready;
  logic [AW:0]    pkt_count;
  logic [AW:0]    fill_level;
  logic [DCW-1:0] drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  // model: committed beats awaiting read, beats of the frame being written
  logic [DW:0] exp_q[$];
  logic [DW:0] part_q[$];
  bit          dropping;
  int          drops;

  always #5 aclk = ~aclk;

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
    .s_axis_tuser(s_axis_tuser),
`endif
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count),
    .fill_level(fill_level),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int n_frames();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][DW]) n++;
    return n;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    dropping = 1'b0;
    drops    = 0;
  endtask

  // One clock cycle: drive at edge+1, check outputs mid-cycle, update model, check status after edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l, input bit u, input bit rdy);
    int occ;
    bit bad;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
    s_axis_tuser  = u;
`endif
    m_axis_tready = rdy;
    #3;
    chk("s_tready", 64'(s_axis_tready), 64'(1));
    if (m_axis_tvalid) begin
      chk("m_beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        chk("m_tdata", 64'(m_axis_tdata), 64'(exp_q[0][DW-1:0]));
        chk("m_tlast", 64'(m_axis_tlast), 64'(exp_q[0][DW]));
      end
    end
    occ = exp_q.size() + part_q.size();
    if (m_axis_tvalid && m_axis_tready && exp_q.size() != 0) void'(exp_q.pop_front());
    bad = BAD_EN && u;
    if (v) begin
      if (dropping) begin
        if (l) begin dropping = 1'b0; drops++; end
      end else if (occ >= DEPTH) begin
        part_q.delete();
        if (l) drops++; else dropping = 1'b1;
      end else begin
        part_q.push_back({l, d});
        if (l) begin
          if (!bad) foreach (part_q[i]) exp_q.push_back(part_q[i]);
          else drops++;
          part_q.delete();
        end
      end
    end
    @(posedge aclk);
    #1;
    chk("pkt_count", 64'(pkt_count), 64'(n_frames()));
    chk("fill_level", 64'(fill_level), 64'(exp_q.size()));
    chk("drop_count", 64'(drop_count), 64'(drops));
  endtask

  task automatic send(input int len, input logic [DW-1:0] base, input bit rdy, input bit u);
    for (int i = 0; i < len; i++) cyc(1'b1, base + DW'(i), (i == len - 1), u && (i == len - 1), rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("drain_done", 64'(exp_q.size()), 64'(0));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
    chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'(0));
    chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'(0));
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'(0));
    chk({tag, "_pkt"}, 64'(pkt_count), 64'(0));
    chk({tag, "_fill"}, 64'(fill_level), 64'(0));
    chk({tag, "_drop"}, 64'(drop_count), 64'(0));
  endtask

  task automatic release_reset();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge aclk);
    #2 areset = 1'b0;
    @(posedge aclk);
    #1;
    model_clear();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    release_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem;
    int drops_before;
    bit v;
    logic [DW-1:0] d;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
    s_axis_tuser  = 1'b0;
`endif
    m_axis_tready = 1'b0;
    model_clear();
    #2;
    check_reset_outputs("rst0");
    #20;
    release_reset();

    // 1: single 4-beat frame, valid rises two edges after the tlast write
    chk("t1_pkt_start", 64'(pkt_count), 64'(0));
    send(4, 32'hA0, 1'b1, 1'b0);
    chk("t1_pkt_one", 64'(pkt_count), 64'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_tvalid_edge1", 64'(m_axis_tvalid), 64'(0));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_tvalid_edge2", 64'(m_axis_tvalid), 64'(1));
    chk("t1_first_beat", 64'(m_axis_tdata), 64'(32'hA0));
    drain();
    chk("t1_pkt_end", 64'(pkt_count), 64'(0));

    // 2: three frames stored while stalled, then released in order
    send(1, 32'hB0, 1'b0, 1'b0);
    send(5, 32'hC0, 1'b0, 1'b0);
    send(2, 32'hD0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t2_pkt", 64'(pkt_count), 64'(3));
    chk("t2_fill", 64'(fill_level), 64'(8));
    drain();

    // 3: oversize frame dropped, following frame forwarded
    do_reset();
    send(20, 32'h100, 1'b1, 1'b0);
    send(3, 32'h200, 1'b1, 1'b0);
    drain();
    chk("t3_drop", 64'(drop_count), 64'(1));

    // 4: second frame does not fit behind the first
    do_reset();
    send(12, 32'h300, 1'b0, 1'b0);
    send(6, 32'h400, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t4_drop", 64'(drop_count), 64'(1));
    chk("t4_fill_held", 64'(fill_level), 64'(12));
    drain();
    chk("t4_fill_end", 64'(fill_level), 64'(0));

    // 5: write commit and read tlast on the same edge, then streaming under backpressure
    do_reset();
    send(1, 32'h500, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_pkt_before", 64'(pkt_count), 64'(1));
    chk("t5_tlast_parked", 64'(m_axis_tlast), 64'(1));
    cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h601, 1'b1, 1'b0, 1'b1);
    chk("t5_pkt_same_edge", 64'(pkt_count), 64'(1));
    rem = 0;
    for (int c = 0; c < 400; c++) begin
      if (rem == 0) rem = $urandom_range(1, 6);
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      cyc(v, d, (rem == 1), 1'b0, c[0]);
      if (v) rem--;
    end
    for (int c = 0; c < 400; c++) begin
      if (rem == 0) rem = $urandom_range(1, 20);
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      cyc(v, d, (rem == 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
      if (v) rem--;
    end
    while (rem != 0) begin
      d = $urandom;
      cyc(1'b1, d, (rem == 1), 1'b0, 1'b1);
      rem--;
    end
    drain();

    // 6: reset mid-frame with two frames stored
    do_reset();
    send(3, 32'h700, 1'b0, 1'b0);
    send(2, 32'h710, 1'b0, 1'b0);
    cyc(1'b1, 32'h720, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h721, 1'b0, 1'b0, 1'b0);
    chk("t6_pkt_before", 64'(pkt_count), 64'(2));
    chk("t6_tvalid_before", 64'(m_axis_tvalid), 64'(1));
    #2 areset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    release_reset();
    send(2, 32'h800, 1'b1, 1'b0);
    drain();

`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
    drops_before = drops;
    send(3, 32'h900, 1'b1, 1'b1);
    drain();
    chk("bad_drop_count", 64'(drop_count), 64'(drops_before + 1));
`else
    drops_before = drops;
    chk("final_drop_count", 64'(drop_count), 64'(drops_before));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Single-clock, parametrised store-and-forward packet FIFO for AXI-Stream frames in the Ethernet RX/TX datapath.
- Buffers multiple complete frames at once.
- Releases a frame downstream only after its tlast beat has been written.
- Drops frames that do not fit in the remaining space, counts the drops, and reports fill and packet occupancy.

Parameters:
- DATA_W, 32, tdata width in bits.
- DEPTH, 256, storage in beats; must be a power of 2, minimum 4.
- DROP_CNT_W, 16, width of the saturating drop counter.
- ADDR_W = $clog2(DEPTH), derived (localparam).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_W  write data.
- s_axis_tvalid  in  1  write beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  write ready.
- m_axis_tdata  out  DATA_W  read data.
- m_axis_tvalid  out  1  read beat valid.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tready  in  1  downstream ready.
- pkt_count  out  ADDR_W+1  number of complete frames stored and not yet fully read.
- fill_level  out  ADDR_W+1  committed-write pointer minus read pointer, in beats.
- drop_count  out  DROP_CNT_W  frames dropped; saturates at all-ones.

Behaviour:
- Reset:
  - Only one clock (aclk) exists. Reset (areset) is asynchronous and active-high.
  - While areset is high, all pointers, counters and outputs are 0, including s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata and all status outputs.
- Storage:
  - Memory is DEPTH x (DATA_W+1); the tlast bit is stored with each beat.
  - Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH.
  - full means (wr_cur - rd_ptr) == DEPTH.
- Write side:
  - s_axis_tready = 1 whenever areset is low. The writer is never stalled; overflow is handled by dropping.
  - State ACCEPT:
    - Each handshake with space writes mem[wr_cur] and increments wr_cur.
    - If a handshake arrives while full, go to DROP and roll wr_cur back to wr_commit.
    - If that beat also has tlast, drop_count increments on the same edge and the state stays ACCEPT.
  - Handshake with tlast while in ACCEPT with space:
    - wr_commit <= wr_cur+1.
    - pkt_count increments on the same edge.
  - State DROP:
    - Beats are discarded.
    - On the tlast handshake, drop_count increments (saturating) and the state returns to ACCEPT.
  - Any frame longer than DEPTH beats is always dropped.
- Read side:
  - A one-entry output register is prefetched from mem[rd_ptr] when committed data exists: rd_ptr != wr_commit and pkt_count > 0.
  - m_axis_tvalid rises exactly 2 clock edges after the tlast write handshake of a frame, provided the FIFO was otherwise empty.
  - On each m handshake the register reloads the next committed beat, or clears m_axis_tvalid if none.
  - This gives a sustained rate of 1 beat/cycle.
  - A tlast read handshake decrements pkt_count.
  - If a write tlast commit and a read tlast handshake occur on the same edge, pkt_count is unchanged.
  - With m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- Space accounting:
  - Space is freed when a beat leaves the output register, not when it is prefetched.
  - An uncommitted frame may use all space not held by committed data.
  - fill_level counts committed beats only.
- Reset mid-operation: all stored and partial frames are lost, and the outputs return to their reset values asynchronously.

Optional Feature:
- Macro: AXIS_PKT_FIFO_BAD_DROP_EN.
- When defined:
  - Adds port s_axis_tuser, in, 1 bit, sampled on the tlast beat.
  - If tuser=1 on the tlast handshake, the frame is discarded: wr_cur is rolled back to wr_commit and drop_count increments. No pkt_count change occurs and the frame is never visible on m_axis.
- When undefined: the port is absent, and all frames that fit are forwarded.

Test Plan:
1. Reset, then write a 4-beat frame 0xA0..0xA3 with m_axis_tready=1.
   - m_axis_tvalid rises 2 edges after the A3 handshake.
   - Output is A0..A3 with tlast on A3 only.
   - pkt_count goes 0->1->0.
2. With m_axis_tready=0, write frames of length 1, 5 and 2 back-to-back.
   - pkt_count=3 and fill_level=8.
   - Then set m_axis_tready=1: the 8 beats emerge in order, with tlast on output beats 1, 6 and 8.
3. DEPTH=16: write a 20-beat frame, then a 3-beat frame.
   - drop_count=1.
   - Only the 3-beat frame is output, and s_axis_tready stays 1 throughout.
4. DEPTH=16, m_axis_tready=0: write a 12-beat frame, then a 6-beat frame, then release.
   - Second frame is dropped (drop_count=1).
   - First frame is output intact, and fill_level returns to 0.
5. Toggle m_axis_tready every cycle while frames stream in, with a write tlast and a read tlast on the same edge.
   - No beat is lost or duplicated, and data holds while stalled.
   - pkt_count is unchanged on that edge.
6. Assert areset mid-frame with 2 frames stored: all outputs are 0 immediately, and after release only new frames appear.
   - With AXIS_PKT_FIFO_BAD_DROP_EN defined: a 3-beat frame with tuser=1 on tlast gives drop_count+1 and no output.
